// File: rtl/instr_mem_loader.sv
// Instruction-memory loader: takes a length-prefixed little-endian byte stream,
// writes it word by word into instruction memory and holds the core meanwhile.
module instr_mem_loader #(
    parameter int unsigned MAX_WORDS = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

    localparam int unsigned CNT_W = $clog2(MAX_WORDS + 1);

    // FLUSH covers the cycle in which the last word's write strobe is out.
    typedef enum logic [2:0] {IDLE, LEN, DATA, FLUSH, DONE} state_t;

    state_t            state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [23:0]       asm_q, asm_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  word_idx_q, word_idx_d;

    logic              byte_ready_d;
    logic              mem_we_d;
    logic [31:0]       mem_addr_d;
    logic [31:0]       mem_wdata_d;
    logic              cpu_hold_d;
    logic              done_d;
    logic              err_d;

    logic              xfer;
    logic [31:0]       word_full;

    assign xfer      = byte_valid && byte_ready;
    assign word_full = {byte_data, asm_q};

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        asm_d        = asm_q;
        len_d        = len_q;
        word_idx_d   = word_idx_q;
        byte_ready_d = byte_ready;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        cpu_hold_d   = cpu_hold;
        done_d       = 1'b0;
        err_d        = err;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = LEN;
                    byte_ready_d = 1'b1;
                    cpu_hold_d   = 1'b1;
                    err_d        = 1'b0;
                    byte_cnt_d   = 2'd0;
                    word_idx_d   = '0;
                end
            end

            LEN: begin
                if (xfer) begin
                    if (byte_cnt_q == 2'd3) begin
                        byte_cnt_d = 2'd0;
                        if (word_full == 32'd0) begin
                            state_d      = DONE;
                            byte_ready_d = 1'b0;
                            cpu_hold_d   = 1'b0;
                            done_d       = 1'b1;
                        end else if (word_full > 32'(MAX_WORDS)) begin
                            state_d      = IDLE;
                            byte_ready_d = 1'b0;
                            cpu_hold_d   = 1'b0;
                            err_d        = 1'b1;
                        end else begin
                            state_d    = DATA;
                            len_d      = word_full[CNT_W-1:0];
                            word_idx_d = '0;
                        end
                    end else begin
                        asm_d      = {byte_data, asm_q[23:8]};
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end

            DATA: begin
                if (xfer) begin
                    if (byte_cnt_q == 2'd3) begin
                        byte_cnt_d  = 2'd0;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = BASE_ADDR + (32'(word_idx_q) << 2);
                        mem_wdata_d = word_full;
                        if ((word_idx_q + CNT_W'(1)) == len_q) begin
                            state_d      = FLUSH;
                            byte_ready_d = 1'b0;
                        end else begin
                            word_idx_d = word_idx_q + CNT_W'(1);
                        end
                    end else begin
                        asm_d      = {byte_data, asm_q[23:8]};
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end

            FLUSH: begin
                state_d    = DONE;
                cpu_hold_d = 1'b0;
                done_d     = 1'b1;
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d      = IDLE;
                byte_ready_d = 1'b0;
                cpu_hold_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            byte_cnt_q <= 2'd0;
            asm_q      <= 24'd0;
            len_q      <= '0;
            word_idx_q <= '0;
            byte_ready <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= BASE_ADDR;
            mem_wdata  <= 32'd0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            byte_ready <= byte_ready_d;
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            cpu_hold   <= cpu_hold_d;
            done       <= done_d;
            err        <= err_d;
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader with a write scoreboard.
module tb_instr_mem_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;

    instr_mem_loader #(.MAX_WORDS(256), .BASE_ADDR(BASE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          done_cnt = 0;
    int          we_cnt = 0;
    int          cyc = 0;
    int          last_we_cyc = 0;
    int          last_done_cyc = 0;
    logic        prev_we = 1'b0;
    logic [63:0] sb[$];
    logic [31:0] prog[8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Write/done monitor, sampled on the falling edge.
    always @(negedge clk) begin
        logic [63:0] e;
        cyc++;
        if (mem_we) begin
            we_cnt++;
            last_we_cyc = cyc;
            e = (sb.size() > 0) ? sb.pop_front() : 64'hx;
            chk("we_addr", mem_addr, e[63:32]);
            chk("we_data", mem_wdata, e[31:0]);
            chk("we_single_cycle", 32'(prev_we), 32'd0);
            chk("we_hold", 32'(cpu_hold), 32'd1);
        end
        if (done) begin
            done_cnt++;
            last_done_cyc = cyc;
            chk("done_hold_low", 32'(cpu_hold), 32'd0);
        end
        prev_we = mem_we;
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        if (gap > 0) begin
            byte_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
        byte_valid = 1'b1;
        byte_data  = b;
        n = 0;
        while (!byte_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("byte_ready_timeout", 32'(n < 200), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_stream(input logic [31:0] n, input int nw, input bit gaps, input int start_at);
        logic [7:0]  b;
        logic [31:0] w;
        for (int i = 0; i < 4 + 4 * nw; i++) begin
            if (i < 4) begin
                b = n[8*i +: 8];
            end else begin
                w = prog[(i - 4) / 4];
                b = w[8*((i - 4) % 4) +: 8];
            end
            if (i == start_at) start = 1'b1;
            send_byte(b, gaps ? int'($urandom_range(0, 5)) : 0);
            start = 1'b0;
        end
        byte_valid = 1'b0;
    endtask

    task automatic wait_done(input int prev);
        int n;
        n = 0;
        while (done_cnt == prev && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("done_seen", 32'(done_cnt), 32'(prev + 1));
    endtask

    task automatic do_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("hold_after_start", 32'(cpu_hold), 32'd1);
        chk("err_cleared_by_start", 32'(err), 32'd0);
    endtask

    // Full successful load of prog[0..nw-1] with header n == nw.
    task automatic run_load(input int nw, input bit gaps, input int start_at);
        int d0, w0;
        d0 = done_cnt;
        w0 = we_cnt;
        for (int k = 0; k < nw; k++) sb.push_back({BASE + 32'(4 * k), prog[k]});
        do_start();
        send_stream(32'(nw), nw, gaps, start_at);
        wait_done(d0);
        chk("write_count", 32'(we_cnt - w0), 32'(nw));
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        chk("err_after_load", 32'(err), 32'd0);
        if (nw > 0) chk("done_after_last_we", 32'(last_done_cyc - last_we_cyc), 32'd1);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("hold_released", 32'(cpu_hold), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, BASE);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        int d0, w0;
        rst_n      = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        #1 rst_n = 1'b0;
        #2;
        chk_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset mid-load after 6 of 12 bytes.
        prog[0] = 32'h0000_0513;
        prog[1] = 32'h0010_0593;
        w0 = we_cnt;
        do_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h13, 0);
        send_byte(8'h05, 0);
        #1 rst_n = 1'b0;
        #1;
        chk_reset_outputs("midload_reset");
        byte_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("no_write_after_reset", 32'(we_cnt - w0), 32'd0);

        // Normal two-word load.
        run_load(2, 1'b0, -1);

        // Zero length.
        run_load(0, 1'b0, -1);

        // Oversize header 257 words.
        d0 = done_cnt;
        w0 = we_cnt;
        do_start();
        send_stream(32'd257, 0, 1'b0, -1);
        repeat (3) @(posedge clk);
        #1;
        chk("oversize_err", 32'(err), 32'd1);
        chk("oversize_hold", 32'(cpu_hold), 32'd0);
        chk("oversize_ready", 32'(byte_ready), 32'd0);
        chk("oversize_no_done", 32'(done_cnt - d0), 32'd0);
        chk("oversize_no_write", 32'(we_cnt - w0), 32'd0);
        // Next start clears err (checked inside do_start).
        run_load(0, 1'b0, -1);

        // Three words, continuous then with random gaps.
        prog[0] = 32'hDEAD_BEEF;
        prog[1] = 32'h0123_4567;
        prog[2] = 32'h89AB_CDEF;
        run_load(3, 1'b0, -1);
        run_load(3, 1'b1, -1);

        // Bytes offered in IDLE are not taken.
        w0 = we_cnt;
        byte_valid = 1'b1;
        byte_data  = 8'h55;
        repeat (5) @(posedge clk);
        #1;
        chk("idle_ready_low", 32'(byte_ready), 32'd0);
        chk("idle_hold_low", 32'(cpu_hold), 32'd0);
        byte_valid = 1'b0;
        chk("idle_no_write", 32'(we_cnt - w0), 32'd0);

        // Start pulsed during DATA is ignored.
        prog[0] = 32'h0000_0513;
        prog[1] = 32'h0010_0593;
        d0 = done_cnt;
        run_load(2, 1'b0, 6);
        repeat (5) @(posedge clk);
        #1;
        chk("single_done_with_start_in_data", 32'(done_cnt - d0), 32'd1);
        chk("no_restart_hold", 32'(cpu_hold), 32'd0);
        chk("no_restart_ready", 32'(byte_ready), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
